// File: rtl/shift_normalizer.sv
// Multi-cycle 32-bit normalizer: finds the left-shift amount (CLZ or CLS)
// by a 16/8/4/2/1 binary search under a start/done handshake.
module shift_normalizer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] X,
    input  logic        LogOrArith,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic [4:0]  shamt,
    output logic        Zero
);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  k;
    logic [31:0] w_reg;
    logic [4:0]  cnt;
    logic        mode;
    logic        xzero;

    logic        accept;
    logic [5:0]  width;
    logic [31:0] mask_l;
    logic [31:0] mask_a;
    logic        hit;
    logic [31:0] w_nx;
    logic [4:0]  cnt_nx;

    assign accept = start && (state != STEP);

    // Logical: top w bits zero. Arithmetic: top w+1 bits all equal.
    always_comb begin
        width  = 6'd1 << k;
        mask_l = ~(32'hFFFF_FFFF >> width);
        mask_a = ~(32'hFFFF_FFFF >> (width + 6'd1));
        if (mode)
            hit = ((w_reg & mask_l) == 32'd0);
        else
            hit = ((w_reg & mask_a) == 32'd0) ||
                  ((w_reg & mask_a) == mask_a);
        w_nx   = hit ? (w_reg << width) : w_reg;
        cnt_nx = hit ? (cnt + width[4:0]) : cnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = STEP;
            STEP:    if (k == 3'd0) state_nx = DONE;
            DONE:    state_nx = start ? STEP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == STEP);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_reg  <= 32'd0;
            cnt    <= 5'd0;
            k      <= 3'd0;
            mode   <= 1'b0;
            xzero  <= 1'b0;
            Result <= 32'd0;
            shamt  <= 5'd0;
            Zero   <= 1'b0;
        end else if (accept) begin
            w_reg <= X;
            cnt   <= 5'd0;
            k     <= 3'd4;
            mode  <= LogOrArith;
            xzero <= (X == 32'd0);
        end else if (state == STEP) begin
            w_reg <= w_nx;
            cnt   <= cnt_nx;
            k     <= k - 3'd1;
            if (k == 3'd0) begin
                Result <= w_nx;
                shamt  <= cnt_nx;
                Zero   <= xzero;
            end
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed-vector and invariant checks for shift_normalizer.
// Inputs change away from the rising edge; outputs are sampled #1 after it.
module tb_shift_normalizer;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] X;
    logic        LogOrArith;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [4:0]  shamt;
    logic        Zero;

    int passed = 0;
    int total  = 0;

    shift_normalizer dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .X          (X),
        .LogOrArith (LogOrArith),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .shamt      (shamt),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic        m;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Bit-serial reference, independent of the binary search.
    function automatic void model(input logic [31:0] x, input logic m,
                                  output logic [4:0] sh,
                                  output logic [31:0] r);
        int n;
        r = x;
        n = 0;
        while (n < 31 && (m ? !r[31] : (r[31] == r[30]))) begin
            r = r << 1;
            n++;
        end
        sh = n[4:0];
    endfunction

    task automatic run_op(input logic [31:0] x, input logic m,
                          output int lat, output int bc,
                          output int holdbad);
        logic [31:0] r0;
        logic [4:0]  s0;
        logic        z0;
        @(negedge clk);
        r0 = Result;
        s0 = shamt;
        z0 = Zero;
        X = x;
        LogOrArith = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        holdbad = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 20) begin
            if (Result !== r0 || shamt !== s0 || Zero !== z0)
                holdbad++;
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
        end
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        int bc;
        int hb;
        int n;
        int dcnt;
        logic [4:0]  msh;
        logic [31:0] mres;
        logic [31:0] rx;
        logic        rm;
        logic        inv;

        vecs[0]  = '{32'h0001_2345, 1'b1, 5'd15, 32'h91A2_8000, 1'b0};
        vecs[1]  = '{32'hFFFF_FF80, 1'b0, 5'd24, 32'h8000_0000, 1'b0};
        vecs[2]  = '{32'h0000_0001, 1'b0, 5'd30, 32'h4000_0000, 1'b0};
        vecs[3]  = '{32'h0000_0000, 1'b1, 5'd31, 32'h0000_0000, 1'b1};
        vecs[4]  = '{32'h8000_0000, 1'b1, 5'd0,  32'h8000_0000, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 1'b0, 5'd31, 32'h8000_0000, 1'b0};
        vecs[6]  = '{32'h0000_0000, 1'b0, 5'd31, 32'h0000_0000, 1'b1};
        vecs[7]  = '{32'h0000_0001, 1'b1, 5'd31, 32'h8000_0000, 1'b0};
        vecs[8]  = '{32'h4000_0000, 1'b0, 5'd0,  32'h4000_0000, 1'b0};
        vecs[9]  = '{32'h00F0_0000, 1'b1, 5'd8,  32'hF000_0000, 1'b0};
        vecs[10] = '{32'hC000_0000, 1'b0, 5'd1,  32'h8000_0000, 1'b0};

        resetn = 1'b0;
        start = 1'b0;
        X = 32'd0;
        LogOrArith = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", Result, 32'd0);
        chk("reset_shamt", {27'd0, shamt}, 32'd0);
        chk("reset_zero", {31'd0, Zero}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].m, lat, bc, hb);
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_busy_cycles", i), bc, 5);
            chk($sformatf("vec%0d_shamt", i), {27'd0, shamt},
                {27'd0, vecs[i].sh});
            chk($sformatf("vec%0d_result", i), Result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'd0, Zero},
                {31'd0, vecs[i].z});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_width", i), {31'd0, done}, 32'd0);
        end

        // start held high through busy while X/mode wander
        @(negedge clk);
        X = 32'h0001_2345;
        LogOrArith = 1'b1;
        start = 1'b1;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done || n >= 20) break;
            X = $urandom;
            LogOrArith = 1'($urandom);
            n++;
        end
        start = 1'b0;
        chk("hold_latency", n, 5);
        chk("hold_shamt", {27'd0, shamt}, 32'd15);
        chk("hold_result", Result, 32'h91A2_8000);
        @(posedge clk);
        #1;
        chk("hold_idle_busy", {31'd0, busy}, 32'd0);
        chk("hold_idle_done", {31'd0, done}, 32'd0);

        // back-to-back start in the DONE cycle
        run_op(32'h00F0_0000, 1'b1, lat, bc, hb);
        chk("b2b_first_shamt", {27'd0, shamt}, 32'd8);
        start = 1'b1;
        X = 32'hC000_0000;
        LogOrArith = 1'b0;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done || n >= 20) break;
        end
        chk("b2b_spacing", n, 6);
        chk("b2b_second_shamt", {27'd0, shamt}, 32'd1);
        chk("b2b_second_result", Result, 32'h8000_0000);

        // asynchronous reset two cycles into an operation
        @(negedge clk);
        X = 32'h0001_2345;
        LogOrArith = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_shamt", {27'd0, shamt}, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);

        // random operands with spread of leading-bit runs
        for (int i = 0; i < 2000; i++) begin
            rx = 32'($urandom) >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rx = ~rx;
            if ($urandom_range(0, 40) == 0) rx = 32'd0;
            if ($urandom_range(0, 40) == 0) rx = 32'hFFFF_FFFF;
            rm = 1'($urandom);
            model(rx, rm, msh, mres);
            run_op(rx, rm, lat, bc, hb);
            chk($sformatf("rnd%0d_latency", i), lat, 5);
            chk($sformatf("rnd%0d_hold", i), hb, 0);
            chk($sformatf("rnd%0d_shamt", i), {27'd0, shamt}, {27'd0, msh});
            chk($sformatf("rnd%0d_result", i), Result, mres);
            chk($sformatf("rnd%0d_zero", i), {31'd0, Zero},
                {31'd0, rx == 32'd0});
            inv = (Result == (rx << shamt));
            if (rm) begin
                if (rx != 32'd0 && !Result[31]) inv = 1'b0;
                if ((Result >> shamt) != rx) inv = 1'b0;
            end else begin
                if (rx != 32'd0 && rx != 32'hFFFF_FFFF &&
                    Result[31] == Result[30]) inv = 1'b0;
                if (32'($signed(Result) >>> shamt) != rx) inv = 1'b0;
            end
            chk($sformatf("rnd%0d_invariants", i), {31'd0, inv}, 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Multi-cycle normalizer: the inverse of the 32-bit barrel shifter. The shifter takes a value and a shift amount. This block takes a value and finds the left-shift amount that normalizes it. In logical mode that amount is the leading-zero count. In arithmetic mode it is the redundant-sign-bit count. The block sits beside the shifter in the datapath and serves CLZ/CLS-style instructions and fixed-point normalization in the game's physics math. It uses a 5-step binary search (16/8/4/2/1) under a start/done handshake.

## Interface
- No parameters; width fixed at 32, shift amount at 5 bits.
- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- X  in  32  operand, captured with start
- LogOrArith  in  1  1 = logical (count leading zeros), 0 = arithmetic (count redundant sign bits); captured with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when outputs update
- Result  out  32  normalized value, equal to X << shamt (zero fill)
- shamt  out  5  shift amount found
- Zero  out  1  1 iff captured X == 0

## Operation
- States: IDLE, STEP, DONE. A 3-bit step counter k runs 4 down to 0; width w = 2^k.
- IDLE/DONE, start=1: capture X into work register W, clear count C, latch mode, set k=4, go to STEP.
- STEP, logical mode: if W[31:32-w] are all zero, then W <= W << w and C <= C + w.
- STEP, arithmetic mode: if the w+1 bits W[31:31-w] are all equal, then W <= W << w and C <= C + w.
- STEP with k=0: apply the step and go to DONE. Load output registers Result=W', shamt=C', Zero=(captured X==0).
- DONE: done=1 for exactly one cycle. With no start, go to IDLE. With start, behave as IDLE (back-to-back accepted).
- Arithmetic: C never exceeds 31, since the sum of all w is 31. No overflow handling is needed.
- Boundary values:
  - Logical X=0 gives shamt=31, Result=0, Zero=1.
  - Arithmetic X=0 gives shamt=31, Result=0, Zero=1.
  - Arithmetic X=0xFFFFFFFF gives shamt=31, Result=0x80000000, Zero=0.
  - Logical X with bit31=1 gives shamt=0, Result=X.
- Invariants after done:
  - Result == X << shamt.
  - Logical, X≠0: Result[31]=1.
  - Arithmetic, X∉{0, 0xFFFFFFFF}: Result[31] != Result[30].
  - Shifting Result right by shamt with the matching LogOrArith restores X.
- Result, shamt and Zero are registered. They change only on the edge entering DONE and otherwise hold their last value.

## Timing
- Reset (resetn low, asynchronous): state=IDLE, busy=0, done=0, Result=0, shamt=0, Zero=0, W=0, C=0.
- Start sampled at edge N. Steps execute at edges N+1 through N+5.
- Edge N+5 enters DONE: done=1 and new outputs are visible in cycle N+5..N+6.
- Latency is 5 cycles from the start edge to done. Throughput is one operation per 6 cycles; back-to-back start in DONE is allowed.
- busy=1 from edge N to edge N+5. busy=0 in DONE.
- start while busy=1 is ignored. X and LogOrArith changes during busy have no effect.
- resetn low mid-operation aborts immediately. No done pulse follows and all outputs return to reset values.
- resetn deassertion is synchronized externally; the first start is honored on the first edge with resetn high.

## Test plan
- Logical X=0x00012345, start -> 5 cycles later done=1, shamt=15, Result=0x91A28000, Zero=0; busy high exactly 5 cycles.
- Arithmetic X=0xFFFFFF80 -> shamt=24, Result=0x80000000. Arithmetic X=0x00000001 -> shamt=30, Result=0x40000000.
- Corners:
  - Logical X=0 -> shamt=31, Result=0, Zero=1.
  - Logical X=0x80000000 -> shamt=0, Result=0x80000000.
  - Arithmetic X=0xFFFFFFFF -> shamt=31, Result=0x80000000, Zero=0.
- Handshake:
  - start held high through busy with X changed each cycle -> only the first X is processed.
  - start in the DONE cycle -> second done exactly 6 cycles after the first.
  - done is never wider than 1 cycle.
- Reset mid-op: start, then resetn low 2 cycles later -> busy=0, done=0, Result=0, shamt=0 immediately. No done follows resetn release until a new start.
- Random: 2000 random X/LogOrArith -> check all invariants above and that the outputs hold between done pulses.
